// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/LSU memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned OUTSTANDING_DEFAULT = 2;
    localparam logic [3:0]  INSTR_BE            = 4'hF;

    function automatic owner_e rr_pick(input owner_e last_grant);
        if (last_grant == OWN_INSTR) begin
            return OWN_DATA;
        end else begin
            return OWN_INSTR;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy-based full/empty; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  fifo_clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push_s, do_pop_s;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; clear empties the queue without touching storage.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (fifo_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and LSU requests onto one pipelined memory port with zero-latency grants.
// Responses return in order; a 1-bit ID FIFO remembers which master owns each one.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = OUTSTANDING_DEFAULT,
    parameter int unsigned DATA_PRIO   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic        instr_valid,
    output logic [31:0] instr_rdata,
    output logic        instr_err,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        spurious_rsp
);

    logic       lock_q, lock_d;
    owner_e     lock_owner_q, lock_owner_d;
    owner_e     last_grant_q, last_grant_d;
    owner_e     owner_s;
    logic       locked_req_s, sel_req_s, accept_s, pop_s;
    logic       id_full_s, id_empty_s;
    logic [0:0] id_head_s, id_push_s;

    // Owner selection: a stalled request keeps the port until granted or abandoned.
    always_comb begin
        locked_req_s = (lock_owner_q == OWN_DATA) ? data_req : instr_req;
        if (lock_q && locked_req_s) begin
            owner_s = lock_owner_q;
        end else if (instr_req && data_req) begin
            if (DATA_PRIO != 0) begin
                owner_s = OWN_DATA;
            end else begin
                owner_s = rr_pick(last_grant_q);
            end
        end else if (data_req) begin
            owner_s = OWN_DATA;
        end else begin
            owner_s = OWN_INSTR;
        end
        sel_req_s = (owner_s == OWN_DATA) ? data_req : instr_req;
    end

    // Memory request mux, grant steering and in-order response routing.
    always_comb begin
        mem_req = sel_req_s & ~id_full_s;
        if (owner_s == OWN_DATA) begin
            mem_addr  = data_addr;
            mem_we    = data_we;
            mem_be    = data_be;
            mem_wdata = data_wdata;
        end else begin
            mem_addr  = instr_addr;
            mem_we    = 1'b0;
            mem_be    = INSTR_BE;
            mem_wdata = 32'h0000_0000;
        end
        accept_s     = mem_req & mem_gnt & ~reset;
        instr_gnt    = accept_s & (owner_s == OWN_INSTR);
        data_gnt     = accept_s & (owner_s == OWN_DATA);
        id_push_s    = owner_s;
        pop_s        = mem_valid & ~id_empty_s & ~reset;
        instr_valid  = pop_s & (owner_e'(id_head_s) == OWN_INSTR);
        data_valid   = pop_s & (owner_e'(id_head_s) == OWN_DATA);
        spurious_rsp = mem_valid & id_empty_s & ~reset;
        instr_rdata  = mem_rdata;
        data_rdata   = mem_rdata;
        instr_err    = mem_err;
        data_err     = mem_err;
    end

    // Lock and round-robin history next-state.
    always_comb begin
        lock_d       = mem_req & ~mem_gnt;
        lock_owner_d = owner_s;
        if (accept_s) begin
            last_grant_d = owner_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INSTR;
            last_grant_q <= OWN_INSTR;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (1),
        .DEPTH      (OUTSTANDING)
    ) u_id_fifo (
        .clk        (clk),
        .fifo_clear (reset),
        .push       (accept_s),
        .push_data  (id_push_s),
        .pop        (pop_s),
        .pop_data   (id_head_s),
        .empty      (id_empty_s),
        .full       (id_full_s)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: one fixed-priority and one round-robin arbiter share stimulus;
// expected grants/responses are queued per instance and checked by a negedge monitor.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        instr_req, data_req, data_we, mem_gnt, mem_valid, mem_err;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_be;

    logic [1:0]  i_gnt, d_gnt, i_val, d_val, i_err, d_err, m_req, m_we, spur;
    logic [31:0] i_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];

    typedef struct packed {
        logic        owner;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t gq0[$];
    gnt_t gq1[$];
    rsp_t rq0[$];
    rsp_t rq1[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter #(.OUTSTANDING(2), .DATA_PRIO(1)) u_dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(i_gnt[0]),
        .instr_valid(i_val[0]), .instr_rdata(i_rdata[0]), .instr_err(i_err[0]),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(d_gnt[0]), .data_valid(d_val[0]),
        .data_rdata(d_rdata[0]), .data_err(d_err[0]),
        .mem_req(m_req[0]), .mem_addr(m_addr[0]), .mem_we(m_we[0]), .mem_be(m_be[0]),
        .mem_wdata(m_wdata[0]), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .spurious_rsp(spur[0])
    );

    mem_arbiter #(.OUTSTANDING(2), .DATA_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(i_gnt[1]),
        .instr_valid(i_val[1]), .instr_rdata(i_rdata[1]), .instr_err(i_err[1]),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(d_gnt[1]), .data_valid(d_val[1]),
        .data_rdata(d_rdata[1]), .data_err(d_err[1]),
        .mem_req(m_req[1]), .mem_addr(m_addr[1]), .mem_we(m_we[1]), .mem_be(m_be[1]),
        .mem_wdata(m_wdata[1]), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .spurious_rsp(spur[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] exp);
        chk(name, 0, a0, exp);
        chk(name, 1, a1, exp);
    endtask

    function automatic gnt_t gi(input logic [31:0] a);
        gnt_t g;
        g.owner = 1'b0; g.addr = a; g.we = 1'b0; g.be = 4'hF; g.wdata = 32'h0;
        return g;
    endfunction

    function automatic gnt_t gd(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        gnt_t g;
        g.owner = 1'b1; g.addr = a; g.we = we; g.be = be; g.wdata = wd;
        return g;
    endfunction

    function automatic rsp_t rs(input logic [1:0] kind, input logic [31:0] rd, input logic err);
        rsp_t r;
        r.kind = kind; r.rdata = rd; r.err = err;
        return r;
    endfunction

    task automatic eg(input int k, input gnt_t g);
        if (k == 0) gq0.push_back(g); else gq1.push_back(g);
    endtask

    task automatic er(input int k, input rsp_t r);
        if (k == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic eg2(input gnt_t g);
        eg(0, g); eg(1, g);
    endtask

    task automatic er2(input rsp_t r);
        er(0, r); er(1, r);
    endtask

    task automatic mon(input int k);
        gnt_t       g;
        rsp_t       r;
        logic [2:0] got_v, exp_v;
        if (i_gnt[k] || d_gnt[k]) begin
            if ((k == 0 && gq0.size() == 0) || (k == 1 && gq1.size() == 0)) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_gnt u%0d: got instr_gnt=%0b data_gnt=%0b expected none", k, i_gnt[k], d_gnt[k]);
            end else begin
                if (k == 0) g = gq0.pop_front(); else g = gq1.pop_front();
                chk("gnt_owner", k, {30'h0, i_gnt[k], d_gnt[k]}, g.owner ? 32'h1 : 32'h2);
                chk("gnt_addr", k, m_addr[k], g.addr);
                chk("gnt_we", k, {31'h0, m_we[k]}, {31'h0, g.we});
                chk("gnt_be", k, {28'h0, m_be[k]}, {28'h0, g.be});
                chk("gnt_wdata", k, m_wdata[k], g.wdata);
            end
        end
        got_v = {i_val[k], d_val[k], spur[k]};
        if (got_v != 3'b000) begin
            if ((k == 0 && rq0.size() == 0) || (k == 1 && rq1.size() == 0)) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_rsp u%0d: got valid/valid/spurious=%b expected none", k, got_v);
            end else begin
                if (k == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                exp_v = (r.kind == 2'd0) ? 3'b100 : ((r.kind == 2'd1) ? 3'b010 : 3'b001);
                chk("rsp_route", k, {29'h0, got_v}, {29'h0, exp_v});
                if (r.kind != 2'd2) begin
                    chk("rsp_instr_rdata", k, i_rdata[k], r.rdata);
                    chk("rsp_data_rdata", k, d_rdata[k], r.rdata);
                    chk("rsp_instr_err", k, {31'h0, i_err[k]}, {31'h0, r.err});
                    chk("rsp_data_err", k, {31'h0, d_err[k]}, {31'h0, r.err});
                end
            end
        end
    endtask

    // Monitor: compares every presented grant or response against the queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            mon(0);
            mon(1);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_addr = 32'h0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    endtask

    task automatic drv_i(input logic [31:0] a);
        instr_req = 1'b1; instr_addr = a;
    endtask

    task automatic drv_d(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        data_req = 1'b1; data_addr = a; data_we = we; data_be = be; data_wdata = wd;
    endtask

    task automatic rsp(input logic [31:0] rd, input logic err);
        mem_valid = 1'b1; mem_rdata = rd; mem_err = err;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        mem_valid = 1'b1; mem_gnt = 1'b1;
        nxt(); nxt();
        // Reset state: nothing requested, memory activity must not leak out.
        mid();
        chk2("rst_mem_req", {31'h0, m_req[0]}, {31'h0, m_req[1]}, 32'h0);
        chk2("rst_gnt", {30'h0, i_gnt[0], d_gnt[0]}, {30'h0, i_gnt[1], d_gnt[1]}, 32'h0);
        chk2("rst_valid", {30'h0, i_val[0], d_val[0]}, {30'h0, i_val[1], d_val[1]}, 32'h0);
        chk2("rst_spurious", {31'h0, spur[0]}, {31'h0, spur[1]}, 32'h0);
        drv_i(32'h40);
        mid();
        chk2("rst_req_passes", {31'h0, m_req[0]}, {31'h0, m_req[1]}, 32'h1);
        chk2("rst_req_no_gnt", {31'h0, i_gnt[0]}, {31'h0, i_gnt[1]}, 32'h0);
        nxt();
        reset = 1'b0; idle();
        nxt();

        // Both request together: data wins on both (round-robin history starts at INSTR).
        drv_i(32'h1000); drv_d(32'h2000, 1'b1, 4'h3, 32'hDEAD_0001); mem_gnt = 1'b1;
        eg2(gd(32'h2000, 1'b1, 4'h3, 32'hDEAD_0001));
        nxt();
        data_req = 1'b0;
        eg2(gi(32'h1000));
        nxt();
        instr_req = 1'b0; rsp(32'h11, 1'b0);
        er2(rs(2'd1, 32'h11, 1'b0));
        nxt();
        rsp(32'h22, 1'b1);
        er2(rs(2'd0, 32'h22, 1'b1));
        nxt();
        idle(); nxt();

        // Two grants fill the ID FIFO; a third request is held off.
        drv_i(32'h400); mem_gnt = 1'b1;
        eg2(gi(32'h400));
        nxt();
        instr_req = 1'b0; drv_d(32'h500, 1'b0, 4'hF, 32'h0);
        eg2(gd(32'h500, 1'b0, 4'hF, 32'h0));
        nxt();
        data_req = 1'b0; drv_i(32'h404);
        mid();
        chk2("full_mem_req", {31'h0, m_req[0]}, {31'h0, m_req[1]}, 32'h0);
        nxt();
        instr_req = 1'b0; rsp(32'hAAAA, 1'b0);
        er2(rs(2'd0, 32'hAAAA, 1'b0));
        nxt();
        rsp(32'hBBBB, 1'b0);
        er2(rs(2'd1, 32'hBBBB, 1'b0));
        nxt();
        idle(); nxt();

        // Both held with responses streaming: RR alternates I,D,I,D; fixed priority starves fetch.
        drv_i(32'h200); drv_d(32'h300, 1'b1, 4'hF, 32'h3030); mem_gnt = 1'b1;
        eg(1, gi(32'h200)); eg(0, gd(32'h300, 1'b1, 4'hF, 32'h3030));
        nxt();
        eg(1, gd(32'h300, 1'b1, 4'hF, 32'h3030)); eg(0, gd(32'h300, 1'b1, 4'hF, 32'h3030));
        nxt();
        rsp(32'hC2, 1'b0);
        er(1, rs(2'd0, 32'hC2, 1'b0)); er(0, rs(2'd1, 32'hC2, 1'b0));
        mid();
        chk2("cap_mem_req", {31'h0, m_req[0]}, {31'h0, m_req[1]}, 32'h0);
        nxt();
        rsp(32'hC3, 1'b0);
        eg(1, gi(32'h200)); er(1, rs(2'd1, 32'hC3, 1'b0));
        eg(0, gd(32'h300, 1'b1, 4'hF, 32'h3030)); er(0, rs(2'd1, 32'hC3, 1'b0));
        nxt();
        rsp(32'hC4, 1'b0);
        eg(1, gd(32'h300, 1'b1, 4'hF, 32'h3030)); er(1, rs(2'd0, 32'hC4, 1'b0));
        eg(0, gd(32'h300, 1'b1, 4'hF, 32'h3030)); er(0, rs(2'd1, 32'hC4, 1'b0));
        nxt();
        instr_req = 1'b0; data_req = 1'b0; rsp(32'hC5, 1'b0);
        er2(rs(2'd1, 32'hC5, 1'b0));
        nxt();
        idle(); nxt();

        // Stalled fetch locks the port; a later LSU request must wait.
        drv_i(32'h100); mem_gnt = 1'b0;
        mid();
        chk2("lock_addr_c0", m_addr[0], m_addr[1], 32'h100);
        nxt();
        drv_d(32'h600, 1'b1, 4'hC, 32'h6666);
        for (int c = 0; c < 2; c++) begin
            mid();
            chk2("lock_addr", m_addr[0], m_addr[1], 32'h100);
            chk2("lock_we", {31'h0, m_we[0]}, {31'h0, m_we[1]}, 32'h0);
            chk2("lock_data_gnt", {31'h0, d_gnt[0]}, {31'h0, d_gnt[1]}, 32'h0);
            nxt();
        end
        mem_gnt = 1'b1;
        eg2(gi(32'h100));
        nxt();
        instr_req = 1'b0;
        eg2(gd(32'h600, 1'b1, 4'hC, 32'h6666));
        nxt();
        data_req = 1'b0; rsp(32'h55, 1'b0);
        er2(rs(2'd0, 32'h55, 1'b0));
        nxt();
        rsp(32'h66, 1'b0);
        er2(rs(2'd1, 32'h66, 1'b0));
        nxt();
        idle(); nxt();

        // Response with nothing outstanding.
        rsp(32'h77, 1'b0);
        er2(rs(2'd2, 32'h0, 1'b0));
        nxt();
        idle(); nxt();

        // Reset with one outstanding: the late response is spurious, then traffic resumes.
        drv_i(32'h800); mem_gnt = 1'b1;
        eg2(gi(32'h800));
        nxt();
        idle(); reset = 1'b1;
        nxt();
        reset = 1'b0; rsp(32'h88, 1'b0);
        er2(rs(2'd2, 32'h0, 1'b0));
        nxt();
        idle(); drv_d(32'h900, 1'b0, 4'hF, 32'h0); mem_gnt = 1'b1;
        eg2(gd(32'h900, 1'b0, 4'hF, 32'h0));
        nxt();
        idle(); rsp(32'h99, 1'b0);
        er2(rs(2'd1, 32'h99, 1'b0));
        nxt();
        idle(); nxt(); nxt();

        chk2("gnt_queue_drained", gq0.size(), gq1.size(), 32'h0);
        chk2("rsp_queue_drained", rq0.size(), rq1.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
